// File: rtl/dcsk_rx_if.sv
// -----------------------------------------------------------------------------
// dcsk_rx_if
//   Chip-stream / message bundle between a DCSK chip source and the dcsk_rx
//   demodulator.
//
//   Signals
//     i_rx        received chip
//     i_rx_valid  i_rx carries a chip this cycle
//     i_sf        spreading-factor code (0:SF2, 1:SF4, 2:SF8, 3:SF16)
//     i_clear     synchronous abort of the frame in progress
//     o_msg       last recovered message, held until the next frame completes
//     o_msg_valid one-cycle pulse when o_msg is updated
//     o_msg_err   qualifies o_msg_valid: a bit decision in the frame was a tie
//     o_busy      a frame is in progress
//
//   Modports
//     master  the chip source / message sink side
//     slave   the demodulator side
// -----------------------------------------------------------------------------
interface dcsk_rx_if #(
    parameter int MSG_W = 32,
    parameter int SF_W  = 2
);
    logic             i_rx;
    logic             i_rx_valid;
    logic [SF_W-1:0]  i_sf;
    logic             i_clear;
    logic [MSG_W-1:0] o_msg;
    logic             o_msg_valid;
    logic             o_msg_err;
    logic             o_busy;

    modport master (
        output i_rx, i_rx_valid, i_sf, i_clear,
        input  o_msg, o_msg_valid, o_msg_err, o_busy
    );

    modport slave (
        input  i_rx, i_rx_valid, i_sf, i_clear,
        output o_msg, o_msg_valid, o_msg_err, o_busy
    );
endinterface

// File: rtl/dcsk_rx.sv
// -----------------------------------------------------------------------------
// dcsk_rx
//   Binary DCSK receiver. Each message bit arrives as L reference chips
//   followed by L data chips (data = ref XOR bit), L = 2^(sf+1). The reference
//   half is buffered, the data half is compared chip by chip against it, and
//   the mismatch count decides the bit by majority. MSG_W bits (MSB first)
//   form one frame; the recovered word is presented with a one-cycle valid
//   pulse.
//
//   Ports
//     i_clk     system clock, rising edge
//     i_arst_n  asynchronous active-low reset
//     bus       dcsk_rx_if slave modport (chip input, control, message output)
// -----------------------------------------------------------------------------
module dcsk_rx #(
    parameter int MSG_W = 32,
    parameter int SF_W  = 2,
    parameter int MAX_L = 16
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    dcsk_rx_if.slave   bus
);

    localparam int CNT_W  = $clog2(MAX_L);   // chip index within a half
    localparam int MISM_W = CNT_W + 1;       // mismatch count 0..MAX_L
    localparam int BIT_W  = $clog2(MSG_W);   // bit index within a frame

    typedef enum logic [1:0] {
        IDLE,
        REF,
        DATA
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   last_q,     last_d;      // L-1 for the current frame
    logic [CNT_W-1:0]   chip_cnt_q, chip_cnt_d;
    logic [MISM_W-1:0]  mism_q,     mism_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [MAX_L-1:0]   ref_q,      ref_d;
    logic [MSG_W-1:0]   shreg_q,    shreg_d;
    logic               err_q,      err_d;       // sticky tie flag
    logic [MSG_W-1:0]   msg_q,      msg_d;
    logic               msg_valid_q, msg_valid_d;
    logic               msg_err_q,  msg_err_d;
    logic               busy_q,     busy_d;

    // Decision datapath for the chip currently on the input.
    logic [MISM_W-1:0]  half_len;
    logic [MISM_W-1:0]  sf_half_len;
    logic [MISM_W-1:0]  mism_sum;
    logic [MISM_W:0]    twice_mism;
    logic               chip_last;
    logic               bit_dec;
    logic               bit_tie;
    logic [MSG_W-1:0]   shreg_next;

    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        chip_cnt_d  = chip_cnt_q;
        mism_d      = mism_q;
        bit_cnt_d   = bit_cnt_q;
        ref_d       = ref_q;
        shreg_d     = shreg_q;
        err_d       = err_q;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        msg_err_d   = msg_err_q;

        // L = 2^(sf+1) written as 2 << sf so the shift amount cannot wrap.
        sf_half_len = MISM_W'(2) << bus.i_sf;
        half_len    = MISM_W'({1'b0, last_q}) + MISM_W'(1);
        chip_last   = (chip_cnt_q == last_q);
        mism_sum    = mism_q + MISM_W'(bus.i_rx ^ ref_q[chip_cnt_q]);
        // Compare 2*mism against L instead of mism against L/2: no rounding.
        twice_mism  = {mism_sum, 1'b0};
        bit_dec     = (twice_mism > {1'b0, half_len});
        bit_tie     = (twice_mism == {1'b0, half_len});
        shreg_next  = {shreg_q[MSG_W-2:0], bit_dec};

        if (bus.i_clear) begin
            // Abort wins over a chip in the same cycle; o_msg is left alone.
            state_d    = IDLE;
            chip_cnt_d = '0;
            mism_d     = '0;
            bit_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (bus.i_rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    last_d     = CNT_W'(sf_half_len - MISM_W'(1));
                    ref_d[0]   = bus.i_rx;
                    chip_cnt_d = CNT_W'(1);
                    mism_d     = '0;
                    bit_cnt_d  = '0;
                    err_d      = 1'b0;
                    state_d    = REF;
                end
                REF: begin
                    ref_d[chip_cnt_q] = bus.i_rx;
                    if (chip_last) begin
                        chip_cnt_d = '0;
                        state_d    = DATA;
                    end else begin
                        chip_cnt_d = chip_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (chip_last) begin
                        shreg_d    = shreg_next;
                        mism_d     = '0;
                        chip_cnt_d = '0;
                        err_d      = err_q | bit_tie;
                        if (bit_cnt_q == BIT_W'(MSG_W - 1)) begin
                            msg_d       = shreg_next;
                            msg_valid_d = 1'b1;
                            msg_err_d   = err_q | bit_tie;
                            bit_cnt_d   = '0;
                            state_d     = IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            state_d   = REF;
                        end
                    end else begin
                        mism_d     = mism_sum;
                        chip_cnt_d = chip_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: non-blocking assignments only in clocked logic, so every flop
    // samples the values from before this edge regardless of statement order.
    // NOTE: the reference buffer is a small flop array, so it is reset along
    // with the rest of the state; no stale chips survive a reset.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= IDLE;
            last_q      <= '0;
            chip_cnt_q  <= '0;
            mism_q      <= '0;
            bit_cnt_q   <= '0;
            ref_q       <= '0;
            shreg_q     <= '0;
            err_q       <= 1'b0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            msg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            chip_cnt_q  <= chip_cnt_d;
            mism_q      <= mism_d;
            bit_cnt_q   <= bit_cnt_d;
            ref_q       <= ref_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            msg_err_q   <= msg_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_msg       = msg_q;
    assign bus.o_msg_valid = msg_valid_q;
    assign bus.o_msg_err   = msg_err_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_dcsk_rx.sv
// -----------------------------------------------------------------------------
// tb_dcsk_rx
//   Directed bench for dcsk_rx. A chip generator inside the bench plays the
//   transmitter: it spreads a message into reference/data halves, optionally
//   flips data chips and inserts idle gaps. Expected words come from the
//   message handed to the generator (or hand-derived for the tie case).
// -----------------------------------------------------------------------------
module tb_dcsk_rx;

    logic clk;
    logic rst_n;

    dcsk_rx_if #(.MSG_W(32), .SF_W(2)) bus ();

    dcsk_rx #(.MSG_W(32), .SF_W(2), .MAX_L(16)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int chip_no = 0;          // chips sampled by the DUT since time 0
    int pulse_cnt = 0;
    int pulse_chips[$];

    // Count valid pulses and remember at which chip each one appeared.
    always @(negedge clk) begin
        if (bus.o_msg_valid === 1'b1) begin
            pulse_cnt++;
            pulse_chips.push_back(chip_no);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_gap(input bit gaps);
        if (gaps && ($urandom_range(0, 3) == 0)) return int'($urandom_range(0, 9));
        return 0;
    endfunction

    // One chip, after 'gap' idle cycles. Returns #1 after the sampling edge.
    task automatic chip(input logic b, input int gap);
        repeat (gap) begin
            bus.i_rx_valid = 1'b0;
            bus.i_rx       = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.i_rx       = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        chip_no++;
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    // Spread one 32-bit message. nflip data chips of every bit are inverted;
    // bit tie_bit gets L/2 flips instead. i_sf is scrambled after the first
    // chip, which the DUT must ignore.
    task automatic send_frame(input int sf, input logic [31:0] msg, input int nflip,
                              input int tie_bit, input bit gaps, input bit fixed_ref,
                              input logic [15:0] ref_pat, input bit busy_chk);
        int len;
        int n;
        int total;
        len   = 2 << sf;
        total = 64 * len;
        n     = 0;
        bus.i_sf = 2'(sf);
        for (int b = 31; b >= 0; b--) begin
            logic [15:0] r;
            int nf;
            r  = fixed_ref ? ref_pat : 16'($urandom);
            nf = (b == tie_bit) ? len / 2 : nflip;
            for (int k = 0; k < len; k++) begin
                chip(r[k], pick_gap(gaps));
                n++;
                if (n == 1) bus.i_sf = 2'($urandom);
                if (busy_chk && n == 1) check("busy_after_chip1", {31'd0, bus.o_busy}, 32'd1);
            end
            for (int k = 0; k < len; k++) begin
                chip(r[k] ^ msg[b] ^ (k < nf), pick_gap(gaps));
                n++;
                if (busy_chk && n == total - 1) check("busy_before_last", {31'd0, bus.o_busy}, 32'd1);
            end
        end
    endtask

    // Right after the final chip's sampling edge the pulse must be up.
    task automatic frame_done(input string tag, input logic [31:0] msg, input logic err);
        check({tag, "_valid"}, {31'd0, bus.o_msg_valid}, 32'd1);
        check({tag, "_msg"}, bus.o_msg, msg);
        check({tag, "_err"}, {31'd0, bus.o_msg_err}, {31'd0, err});
    endtask

    task automatic idle(input int n);
        bus.i_rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int pc0;
        int q0;
        int base;
        logic [31:0] m;
        int sf;

        bus.i_rx       = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_sf       = 2'd0;
        bus.i_clear    = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_msg",   bus.o_msg, 32'h0);
        check("rst_valid", {31'd0, bus.o_msg_valid}, 32'd0);
        check("rst_err",   {31'd0, bus.o_msg_err}, 32'd0);
        check("rst_busy",  {31'd0, bus.o_busy}, 32'd0);
        @(posedge clk);
        #1;

        // SF2, fixed reference "10", continuous chips, busy profile.
        send_frame(0, 32'h8000_0001, 0, -1, 1'b0, 1'b1, 16'h0001, 1'b1);
        frame_done("sf2", 32'h8000_0001, 1'b0);
        check("sf2_busy_end", {31'd0, bus.o_busy}, 32'd0);
        idle(2);
        check("sf2_valid_drop", {31'd0, bus.o_msg_valid}, 32'd0);
        check("sf2_pulses", pulse_cnt, 32'd1);

        // SF16 with random reference and random gaps.
        pc0 = pulse_cnt;
        send_frame(3, 32'hA5A5_0F0F, 0, -1, 1'b1, 1'b0, 16'h0, 1'b0);
        frame_done("sf16", 32'hA5A5_0F0F, 1'b0);
        idle(5);
        check("sf16_one_pulse", pulse_cnt - pc0, 32'd1);
        check("sf16_msg_held", bus.o_msg, 32'hA5A5_0F0F);

        // SF8 noise below threshold, then an exact tie in bit 0.
        send_frame(2, 32'hDEAD_BEEF, 3, -1, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("sf8_noise", 32'hDEAD_BEEF, 1'b0);
        idle(1);
        send_frame(2, 32'hDEAD_BEEF, 3, 0, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("sf8_tie", 32'hDEAD_BEEE, 1'b1);
        idle(1);

        // Back-to-back SF4 then SF2, no idle cycle in between.
        q0   = pulse_chips.size();
        base = chip_no;
        send_frame(1, 32'h1234_5678, 0, -1, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("b2b_1", 32'h1234_5678, 1'b0);
        send_frame(0, 32'hFFFF_0000, 0, -1, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("b2b_2", 32'hFFFF_0000, 1'b0);
        idle(2);
        check("b2b_pulses", pulse_chips.size() - q0, 32'd2);
        if (pulse_chips.size() - q0 == 2) begin
            check("b2b_gap1", pulse_chips[q0] - base, 32'd256);
            check("b2b_gap2", pulse_chips[q0 + 1] - pulse_chips[q0], 32'd128);
        end

        // Abort with i_clear after 100 SF4 chips; a chip in the same cycle is dropped.
        pc0 = pulse_cnt;
        bus.i_sf = 2'd1;
        for (int i = 0; i < 100; i++) chip(1'($urandom), 0);
        check("clr_busy_mid", {31'd0, bus.o_busy}, 32'd1);
        bus.i_clear    = 1'b1;
        bus.i_rx       = 1'b1;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clear    = 1'b0;
        bus.i_rx_valid = 1'b0;
        check("clr_busy", {31'd0, bus.o_busy}, 32'd0);
        check("clr_msg_kept", bus.o_msg, 32'hFFFF_0000);
        send_frame(1, 32'h0000_00FF, 0, -1, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("clr_after", 32'h0000_00FF, 1'b0);
        idle(2);
        check("clr_one_pulse", pulse_cnt - pc0, 32'd1);

        // Same abort done with an asynchronous reset pulse.
        for (int i = 0; i < 100; i++) chip(1'($urandom), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_msg",   bus.o_msg, 32'h0);
        check("arst_valid", {31'd0, bus.o_msg_valid}, 32'd0);
        check("arst_err",   {31'd0, bus.o_msg_err}, 32'd0);
        check("arst_busy",  {31'd0, bus.o_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pc0 = pulse_cnt;
        send_frame(1, 32'h0000_00FF, 0, -1, 1'b0, 1'b0, 16'h0, 1'b0);
        frame_done("arst_after", 32'h0000_00FF, 1'b0);
        idle(2);
        check("arst_one_pulse", pulse_cnt - pc0, 32'd1);

        // Random loopback: random SF, message and bursts, mostly back-to-back.
        pc0 = pulse_cnt;
        for (int f = 0; f < 30; f++) begin
            m  = $urandom;
            sf = int'($urandom_range(0, 3));
            send_frame(sf, m, 0, -1, 1'b1, 1'b0, 16'h0, 1'b0);
            frame_done("loop", m, 1'b0);
        end
        idle(3);
        check("loop_pulses", pulse_cnt - pc0, 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
